interrupt_controller: RTL and testbench

- Central interrupt controller serving `NUM_IRQ` peripheral sources, such as the system timer.
- Uses a 3-wire IRQ/IACK/IEND handshake with each source.
- Presents one interrupt line plus a vector index to the CPU.
- Arbitrates with fixed priority (index 0 highest) and services one interrupt at a time, without nesting.
- Exposes a software-writable enable mask.

---
 rtl/interrupt_controller.sv | 119 +++++++++++
 tb/tb_interrupt_controller.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - fixed-priority interrupt controller with IRQ/IACK/IEND source handshake
module interrupt_controller #(
  parameter int                 NUM_IRQ    = 4,
  parameter int                 IDX_W      = 2,
  parameter logic [NUM_IRQ-1:0] MASK_RESET = '1
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [NUM_IRQ-1:0] INTC_IRQ,
  output logic [NUM_IRQ-1:0] INTC_IACK,
  output logic [NUM_IRQ-1:0] INTC_IEND,
  output logic               CPU_INT,
  output logic [IDX_W-1:0]   CPU_VECTOR,
  input  logic               CPU_ACK,
  input  logic               CPU_EOI,
  input  logic               MASK_WE,
  input  logic [NUM_IRQ-1:0] MASK_DIN,
  output logic [NUM_IRQ-1:0] MASK_Q
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PEND,
    ST_SERV,
    ST_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     cur_q, cur_d;
  logic [NUM_IRQ-1:0]   mask_q, mask_d;
  logic [NUM_IRQ-1:0]   iack_q, iack_d;
  logic [NUM_IRQ-1:0]   iend_q, iend_d;
  logic                 int_q, int_d;
  logic [IDX_W-1:0]     vec_q, vec_d;

  logic [NUM_IRQ-1:0]   req;
  logic [NUM_IRQ-1:0]   cur_onehot;
  logic [IDX_W-1:0]     low_idx;

  assign req        = INTC_IRQ & mask_q;
  assign cur_onehot = NUM_IRQ'(1) << cur_q;

  // Lowest set index of the enabled requests wins arbitration.
  always_comb begin
    low_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) low_idx = IDX_W'(i);
    end
  end

  // Next state, current source and the registered output values.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    iack_d  = '0;
    iend_d  = '0;
    mask_d  = MASK_WE ? MASK_DIN : mask_q;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          cur_d   = low_idx;
          state_d = ST_PEND;
        end
      end
      ST_PEND: begin
        // An ACK in the same cycle as a drop still commits to service.
        if (CPU_ACK) begin
          state_d = ST_SERV;
          iack_d  = cur_onehot;
        end else if ((req & cur_onehot) == '0) begin
          state_d = ST_IDLE;
        end
      end
      ST_SERV: begin
        if (CPU_EOI) begin
          state_d = ST_DONE;
          iend_d  = cur_onehot;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    int_d = (state_d == ST_PEND);
    // The vector follows the source being handled and freezes in IDLE.
    vec_d = (state_d == ST_IDLE) ? vec_q : cur_d;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= ST_IDLE;
      cur_q   <= '0;
      mask_q  <= MASK_RESET;
      iack_q  <= '0;
      iend_q  <= '0;
      int_q   <= 1'b0;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      mask_q  <= mask_d;
      iack_q  <= iack_d;
      iend_q  <= iend_d;
      int_q   <= int_d;
      vec_q   <= vec_d;
    end
  end

  assign INTC_IACK  = iack_q;
  assign INTC_IEND  = iend_q;
  assign CPU_INT    = int_q;
  assign CPU_VECTOR = vec_q;
  assign MASK_Q     = mask_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// tb/tb_interrupt_controller.sv - randomized and directed self-checking bench for interrupt_controller
module tb_interrupt_controller;

  localparam int NUM_IRQ      = 4;
  localparam int IDX_W        = 2;
  localparam int CLOCKS_TIMER = 20;

  logic               CLK;
  logic               RESET;
  logic [NUM_IRQ-1:0] INTC_IRQ;
  logic [NUM_IRQ-1:0] INTC_IACK;
  logic [NUM_IRQ-1:0] INTC_IEND;
  logic               CPU_INT;
  logic [IDX_W-1:0]   CPU_VECTOR;
  logic               CPU_ACK;
  logic               CPU_EOI;
  logic               MASK_WE;
  logic [NUM_IRQ-1:0] MASK_DIN;
  logic [NUM_IRQ-1:0] MASK_Q;

  interrupt_controller #(
    .NUM_IRQ   (NUM_IRQ),
    .IDX_W     (IDX_W),
    .MASK_RESET(4'b1111)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .INTC_IRQ  (INTC_IRQ),
    .INTC_IACK (INTC_IACK),
    .INTC_IEND (INTC_IEND),
    .CPU_INT   (CPU_INT),
    .CPU_VECTOR(CPU_VECTOR),
    .CPU_ACK   (CPU_ACK),
    .CPU_EOI   (CPU_EOI),
    .MASK_WE   (MASK_WE),
    .MASK_DIN  (MASK_DIN),
    .MASK_Q    (MASK_Q)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: which source is owned, and how far its service has got.
  // m_phase: 0 = nothing owned, 1 = offered to CPU, 2 = CPU servicing, 3 = ending.
  int m_phase = 0;
  int m_cur   = 0;
  int m_mask  = 15;
  int e_int   = 0;
  int e_vec   = 0;
  int e_iack  = 0;
  int e_iend  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int lowest_set(input int v);
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (v[i]) return i;
    end
    return 0;
  endfunction

  task automatic model_edge(input bit rstn, input int irq, input bit ack, input bit eoi,
                            input bit we, input int din);
    int req;
    req    = irq & m_mask;
    e_iack = 0;
    e_iend = 0;
    if (!rstn) begin
      m_phase = 0;
      m_cur   = 0;
      m_mask  = 15;
      e_int   = 0;
      e_vec   = 0;
      return;
    end
    if (m_phase == 0) begin
      if (req != 0) begin
        m_cur   = lowest_set(req);
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (ack) begin
        m_phase = 2;
        e_iack  = 1 << m_cur;
      end else if (req[m_cur] == 1'b0) begin
        m_phase = 0;
      end
    end else if (m_phase == 2) begin
      if (eoi) begin
        m_phase = 3;
        e_iend  = 1 << m_cur;
      end
    end else begin
      m_phase = 0;
    end
    if (we) m_mask = din;
    e_int = (m_phase == 1) ? 1 : 0;
    if (m_phase != 0) e_vec = m_cur;
  endtask

  // One clock: drive at the falling edge, let the model see the rising edge,
  // then compare every output at the next falling edge.
  task automatic step(input bit rstn, input logic [3:0] irq, input bit ack, input bit eoi,
                      input bit we, input logic [3:0] din);
    RESET    = rstn;
    INTC_IRQ = irq;
    CPU_ACK  = ack;
    CPU_EOI  = eoi;
    MASK_WE  = we;
    MASK_DIN = din;
    @(posedge CLK);
    model_edge(rstn, int'(irq), ack, eoi, we, int'(din));
    @(negedge CLK);
    check_eq("cpu_int", 32'(CPU_INT), 32'(e_int));
    check_eq("cpu_vector", 32'(CPU_VECTOR), 32'(e_vec));
    check_eq("intc_iack", 32'(INTC_IACK), 32'(e_iack));
    check_eq("intc_iend", 32'(INTC_IEND), 32'(e_iend));
    check_eq("mask_q", 32'(MASK_Q), 32'(m_mask));
    check_eq("ack_end_onehot", 32'($countones(INTC_IACK | INTC_IEND) <= 1), 32'd1);
  endtask

  initial begin
    logic [3:0] irq_r;
    int tmr, fires, n_iack, n_iend, wait_cnt, svc_cnt;
    bit irq0, ack_t, eoi_t;

    RESET    = 1'b0;
    INTC_IRQ = '0;
    CPU_ACK  = 1'b0;
    CPU_EOI  = 1'b0;
    MASK_WE  = 1'b0;
    MASK_DIN = '0;
    @(negedge CLK);

    // Reset held with every source requesting.
    for (int i = 0; i < 3; i++) step(0, 4'b1111, 0, 0, 0, 4'h0);
    check_eq("rst_int", 32'(CPU_INT), 32'd0);
    check_eq("rst_mask", 32'(MASK_Q), 32'hF);
    check_eq("rst_iack", 32'(INTC_IACK), 32'd0);
    step(1, 4'b1111, 0, 0, 0, 4'h0);
    check_eq("rel_int", 32'(CPU_INT), 32'd1);
    check_eq("rel_vec", 32'(CPU_VECTOR), 32'd0);
    step(0, 4'b0000, 0, 0, 0, 4'h0);

    // Single source on bit 2.
    step(1, 4'b0100, 0, 0, 0, 4'h0);
    check_eq("sgl_int", 32'(CPU_INT), 32'd1);
    check_eq("sgl_vec", 32'(CPU_VECTOR), 32'd2);
    step(1, 4'b0100, 0, 0, 0, 4'h0);
    step(1, 4'b0100, 1, 0, 0, 4'h0);
    check_eq("sgl_iack", 32'(INTC_IACK), 32'h4);
    check_eq("sgl_int_off", 32'(CPU_INT), 32'd0);
    step(1, 4'b0000, 0, 0, 0, 4'h0);
    check_eq("sgl_iack_once", 32'(INTC_IACK), 32'h0);
    step(1, 4'b0000, 0, 1, 0, 4'h0);
    check_eq("sgl_iend", 32'(INTC_IEND), 32'h4);
    for (int i = 0; i < 3; i++) step(1, 4'b0000, 0, 0, 0, 4'h0);
    check_eq("sgl_quiet", 32'(CPU_INT), 32'd0);

    // Priority: bits 1 and 3 together.
    step(1, 4'b1010, 0, 0, 0, 4'h0);
    check_eq("pri_vec1", 32'(CPU_VECTOR), 32'd1);
    step(1, 4'b1010, 1, 0, 0, 4'h0);
    check_eq("pri_iack1", 32'(INTC_IACK), 32'h2);
    step(1, 4'b1000, 0, 1, 0, 4'h0);
    check_eq("pri_iend1", 32'(INTC_IEND), 32'h2);
    step(1, 4'b1000, 0, 0, 0, 4'h0);
    step(1, 4'b1000, 0, 0, 0, 4'h0);
    check_eq("pri_vec3", 32'(CPU_VECTOR), 32'd3);
    step(1, 4'b1000, 1, 0, 0, 4'h0);
    check_eq("pri_iack3", 32'(INTC_IACK), 32'h8);
    step(1, 4'b0000, 0, 1, 0, 4'h0);
    check_eq("pri_iend3", 32'(INTC_IEND), 32'h8);
    step(1, 4'b0000, 0, 0, 0, 4'h0);

    // Mask: source 0 disabled, then re-enabled.
    step(1, 4'b0000, 0, 0, 1, 4'b1110);
    for (int i = 0; i < 3; i++) step(1, 4'b0001, 0, 0, 0, 4'h0);
    check_eq("msk_blocked", 32'(CPU_INT), 32'd0);
    step(1, 4'b0001, 0, 0, 1, 4'b1111);
    check_eq("msk_t1", 32'(CPU_INT), 32'd0);
    step(1, 4'b0001, 0, 0, 0, 4'h0);
    check_eq("msk_t2", 32'(CPU_INT), 32'd1);
    step(1, 4'b0000, 0, 0, 0, 4'h0);
    check_eq("msk_cancel", 32'(CPU_INT), 32'd0);

    // Cancel by drop, then drop together with ACK.
    step(1, 4'b0100, 0, 0, 0, 4'h0);
    step(1, 4'b0000, 0, 0, 0, 4'h0);
    check_eq("cnl_int", 32'(CPU_INT), 32'd0);
    check_eq("cnl_iack", 32'(INTC_IACK), 32'h0);
    step(1, 4'b0000, 0, 0, 0, 4'h0);
    step(1, 4'b0100, 0, 0, 0, 4'h0);
    step(1, 4'b0000, 1, 0, 0, 4'h0);
    check_eq("cnl_ack_wins", 32'(INTC_IACK), 32'h4);

    // Reset during service: no IEND afterwards.
    step(1, 4'b0000, 0, 0, 0, 4'h0);
    step(0, 4'b0000, 0, 1, 0, 4'h0);
    check_eq("mrst_iend", 32'(INTC_IEND), 32'h0);
    for (int i = 0; i < 3; i++) step(1, 4'b0000, 0, 1, 0, 4'h0);
    check_eq("mrst_quiet", 32'(INTC_IEND | INTC_IACK), 32'h0);

    // Loopback: periodic timer on source 0 with a slow CPU.
    tmr = 0; fires = 0; n_iack = 0; n_iend = 0; wait_cnt = 0; svc_cnt = -1; irq0 = 0;
    for (int c = 0; c < 260; c++) begin
      if (INTC_IACK[0]) begin
        n_iack++;
        irq0    = 0;
        svc_cnt = 0;
      end
      if (INTC_IEND[0]) n_iend++;
      if (c < 10 * CLOCKS_TIMER) begin
        if (tmr == CLOCKS_TIMER - 1) begin
          tmr = 0;
          irq0 = 1;
          fires++;
        end else begin
          tmr++;
        end
      end
      ack_t    = CPU_INT && (wait_cnt >= 2);
      wait_cnt = CPU_INT ? wait_cnt + 1 : 0;
      eoi_t    = 0;
      if (svc_cnt >= 0) begin
        svc_cnt++;
        if (svc_cnt == 5) begin
          eoi_t   = 1;
          svc_cnt = -1;
        end
      end
      step(1, {3'b000, irq0}, ack_t, eoi_t, 0, 4'h0);
    end
    check_eq("tmr_fires", 32'(fires), 32'd10);
    check_eq("tmr_iack", 32'(n_iack), 32'(fires));
    check_eq("tmr_iend", 32'(n_iend), 32'(fires));

    // Randomized traffic against the model.
    irq_r = 4'h0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(3) == 0) irq_r = 4'($urandom);
      step(($urandom_range(49) != 0), irq_r, ($urandom_range(2) == 0), ($urandom_range(2) == 0),
           ($urandom_range(11) == 0), 4'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
